// File: rtl/dbg_ctrl.sv
// Debug halt controller for an in-order pipeline.
// Traps on EBREAK or an external halt request, drains the pipeline for a
// fixed number of cycles, then holds in HALT until the debugger resumes or
// single-steps. It also counts retired instructions in every state.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   ebreak_d       - EBREAK in decode
//   halt_req       - external halt request (level)
//   resume_req     - leave HALT and run freely (level)
//   step_req       - execute one instruction from HALT (level)
//   retire_w       - valid instruction retiring in writeback
//   stall_fetch    - freeze fetch PC and IF/ID (combinational in the trap cycle)
//   halted         - registered decode of HALT
//   cause          - halt cause: 00 none, 01 ebreak, 10 halt_req, 11 step
//   retire_cnt     - retired instruction count, wraps
module dbg_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ebreak_d,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             step_req,
    input  logic             retire_w,
    output logic             stall_fetch,
    output logic             halted,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int unsigned DW = 4;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_EBREAK = 2'b01;
    localparam logic [1:0] CAUSE_HALT   = 2'b10;
    localparam logic [1:0] CAUSE_STEP   = 2'b11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2,
        STEP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    cause_nxt;
    logic [DW-1:0] dcnt;
    logic          mask;
    logic          trap_c;
    logic          stall_c;

    // EBREAK is ignored for the first cycle after leaving HALT so the
    // instruction we resumed or stepped onto does not trap again.
    assign trap_c = ebreak_d && !mask;

    // Next-state and cause decode; stall is raised in the triggering RUN cycle.
    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        stall_c   = 1'b0;
        case (state)
            RUN: begin
                if (trap_c) begin
                    state_nxt = DRAIN;
                    cause_nxt = CAUSE_EBREAK;
                    stall_c   = 1'b1;
                end else if (halt_req) begin
                    state_nxt = DRAIN;
                    cause_nxt = CAUSE_HALT;
                    stall_c   = 1'b1;
                end
            end
            DRAIN: begin
                stall_c = 1'b1;
                if (dcnt == '0) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                stall_c = 1'b1;
                if (resume_req) begin
                    state_nxt = RUN;
                    cause_nxt = CAUSE_NONE;
                end else if (step_req) begin
                    state_nxt = STEP;
                end
            end
            STEP: begin
                state_nxt = DRAIN;
                cause_nxt = trap_c ? CAUSE_EBREAK : CAUSE_STEP;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign stall_fetch = stall_c;

    // State, drain counter, mask, registered outputs and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            dcnt       <= '0;
            mask       <= 1'b0;
            halted     <= 1'b0;
            cause      <= CAUSE_NONE;
            retire_cnt <= '0;
        end else begin
            state  <= state_nxt;
            cause  <= cause_nxt;
            halted <= (state_nxt == HALT);
            mask   <= (state == HALT) && (state_nxt != HALT);

            if ((state_nxt == DRAIN) && (state != DRAIN)) begin
                dcnt <= DW'(DRAIN_CYCLES - 1);
            end else if ((state == DRAIN) && (dcnt != '0)) begin
                dcnt <= dcnt - DW'(1);
            end

            if (retire_w) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dbg_ctrl.sv
// Directed bench for dbg_ctrl (DRAIN_CYCLES=3, CNT_W=4). Inputs change on the
// falling edge; outputs are checked 1ns later, so each vector describes one
// clock cycle: its inputs and the outputs expected during that cycle.
module tb_dbg_ctrl;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic          ebreak_d;
    logic          halt_req;
    logic          resume_req;
    logic          step_req;
    logic          retire_w;
    logic          stall_fetch;
    logic          halted;
    logic [1:0]    cause;
    logic [CW-1:0] retire_cnt;

    int n_checks;
    int n_pass;

    dbg_ctrl #(
        .DRAIN_CYCLES(3),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ebreak_d   (ebreak_d),
        .halt_req   (halt_req),
        .resume_req (resume_req),
        .step_req   (step_req),
        .retire_w   (retire_w),
        .stall_fetch(stall_fetch),
        .halted     (halted),
        .cause      (cause),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          e;
        logic          h;
        logic          r;
        logic          s;
        logic          w;
        logic          x_stall;
        logic          x_halted;
        logic [1:0]    x_cause;
        logic [CW-1:0] x_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic st, input logic hl,
                             input logic [1:0] ca, input logic [CW-1:0] cn);
        check({tag, " stall_fetch"}, int'(stall_fetch), int'(st));
        check({tag, " halted"},      int'(halted),      int'(hl));
        check({tag, " cause"},       int'(cause),       int'(ca));
        check({tag, " retire_cnt"},  int'(retire_cnt),  int'(cn));
    endtask

    task automatic add(input logic e, input logic h, input logic r, input logic s,
                       input logic w, input logic st, input logic hl,
                       input logic [1:0] ca, input logic [CW-1:0] cn);
        vec_t v;
        v.e = e; v.h = h; v.r = r; v.s = s; v.w = w;
        v.x_stall = st; v.x_halted = hl; v.x_cause = ca; v.x_cnt = cn;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic e, input logic h, input logic r,
                         input logic s, input logic w);
        ebreak_d = e; halt_req = h; resume_req = r; step_req = s; retire_w = w;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        drive(0, 0, 0, 0, 0);

        //   e  h  r  s  w | stall halted cause cnt
        // EBREAK trap, inputs ignored while draining, retires counted in DRAIN
        add(0, 0, 0, 0, 1,   0, 0, 2'd0, 4'd0);
        add(1, 0, 0, 0, 0,   1, 0, 2'd0, 4'd1);
        add(0, 0, 0, 0, 1,   1, 0, 2'd1, 4'd1);
        add(1, 1, 1, 1, 0,   1, 0, 2'd1, 4'd2);
        add(0, 0, 0, 0, 0,   1, 0, 2'd1, 4'd2);
        add(0, 0, 0, 0, 0,   1, 1, 2'd1, 4'd2);
        // single step with EBREAK held: one unstalled cycle, drain, cause 11
        add(1, 0, 0, 1, 0,   1, 1, 2'd1, 4'd2);
        add(1, 0, 0, 0, 1,   0, 0, 2'd1, 4'd2);
        add(1, 0, 0, 0, 0,   1, 0, 2'd3, 4'd3);
        add(0, 0, 0, 0, 0,   1, 0, 2'd3, 4'd3);
        add(0, 0, 0, 0, 0,   1, 0, 2'd3, 4'd3);
        add(0, 0, 0, 0, 0,   1, 1, 2'd3, 4'd3);
        // resume and step together: resume wins; EBREAK masked one cycle only
        add(1, 0, 1, 1, 0,   1, 1, 2'd3, 4'd3);
        add(1, 0, 0, 0, 0,   0, 0, 2'd0, 4'd3);
        add(1, 0, 0, 0, 0,   1, 0, 2'd0, 4'd3);
        add(0, 0, 0, 0, 1,   1, 0, 2'd1, 4'd3);
        add(0, 0, 0, 0, 1,   1, 0, 2'd1, 4'd4);
        add(0, 0, 0, 0, 0,   1, 0, 2'd1, 4'd5);
        add(0, 0, 0, 0, 0,   1, 1, 2'd1, 4'd5);
        // halt_req is not masked after resume
        add(0, 0, 1, 0, 0,   1, 1, 2'd1, 4'd5);
        add(0, 1, 0, 0, 0,   1, 0, 2'd0, 4'd5);
        add(0, 0, 0, 0, 0,   1, 0, 2'd2, 4'd5);
        add(0, 0, 0, 0, 0,   1, 0, 2'd2, 4'd5);
        add(0, 0, 0, 0, 0,   1, 0, 2'd2, 4'd5);
        add(0, 0, 0, 0, 0,   1, 1, 2'd2, 4'd5);
        add(0, 0, 1, 0, 0,   1, 1, 2'd2, 4'd5);
        add(0, 0, 0, 0, 0,   0, 0, 2'd0, 4'd5);
        // EBREAK and halt_req together: EBREAK wins
        add(1, 1, 0, 0, 0,   1, 0, 2'd0, 4'd5);
        add(0, 0, 0, 0, 0,   1, 0, 2'd1, 4'd5);
        add(0, 0, 0, 0, 0,   1, 0, 2'd1, 4'd5);
        add(0, 0, 0, 0, 0,   1, 0, 2'd1, 4'd5);
        add(0, 0, 1, 0, 0,   1, 1, 2'd1, 4'd5);
        add(0, 0, 0, 0, 0,   0, 0, 2'd0, 4'd5);

        // reset state
        #1;
        check_all("reset", 0, 0, 2'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].e, vecs[i].h, vecs[i].r, vecs[i].s, vecs[i].w);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].x_stall, vecs[i].x_halted,
                      vecs[i].x_cause, vecs[i].x_cnt);
        end

        // retire counter wrap: 10 more retires reach 15, 2 more wrap to 1
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        check("cnt_at_15", int'(retire_cnt), 15);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        check("cnt_wrapped", int'(retire_cnt), 1);

        // asynchronous reset in the second DRAIN cycle
        @(negedge clk);
        drive(0, 1, 0, 0, 0);
        #1;
        check("rst_seq trigger stall", int'(stall_fetch), 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        check_all("rst_seq drain1", 1, 0, 2'd2, 4'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_seq in_reset", 0, 0, 2'd0, 4'd0);

        // first edge after release already reacts to halt_req
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 0, 0);
        #1;
        check_all("post_rst trigger", 1, 0, 2'd0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0);
            #1;
            check_all($sformatf("post_rst drain%0d", k), 1, 0, 2'd2, 4'd0);
        end
        @(negedge clk);
        #1;
        check_all("post_rst halt", 1, 1, 2'd2, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
